// File: rtl/aes_inv_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_inv_round_ctrl
//
// Purpose:
//   Control unit for an iterative AES inverse cipher that runs one round per
//   clock. It owns the 128-bit state register, the round counter and the
//   round-key index sequencing, and it implements the valid/ready handshakes
//   on both sides. The inverse-round datapath (inv_shift_rows ->
//   inv_sub_bytes -> add_round_key -> inv_mix_columns) sits outside this
//   block and is purely combinational. This block feeds that datapath from
//   the state register and loads its result back on every round.
//
//   Block flow:
//     IDLE  : request key NR, accept ciphertext, apply the initial AddRoundKey
//     ROUND : request key cnt, load the datapath result, count cnt down to 0
//     DONE  : present plaintext until the consumer takes it
//
// Parameters:
//   NR      number of rounds (10/12/14 for AES-128/192/256)
//   KIDX_W  width of the round-key index; 2**KIDX_W must exceed NR
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   i_flush      synchronous abort; the block is dropped and the FSM returns to IDLE
//   i_valid      ciphertext block valid
//   o_in_ready   ready for a ciphertext block (IDLE only, never during flush)
//   i_data       ciphertext block
//   o_key_idx    round-key index requested this cycle
//   i_round_key  round key for o_key_idx, returned combinationally
//   o_rnd_data   state presented to the inverse-round datapath
//   o_last_rnd   last round: the datapath bypasses inv_mix_columns
//   i_rnd_data   inverse-round datapath result
//   o_valid      plaintext valid
//   i_ready      downstream ready
//   o_data       plaintext (the same register as o_rnd_data)
//   o_busy       high while a block is in ROUND or DONE
//   i_key_valid  (AES_KEY_VALID_EN only) the key for o_key_idx is available
//
// Configuration macro:
//   AES_KEY_VALID_EN  adds i_key_valid. The accept step and every round
//                     update wait for it. While it is low, the state and the
//                     key index hold.
// -----------------------------------------------------------------------------
module aes_inv_round_ctrl #(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_in_ready,
    input  logic [127:0]      i_data,
    output logic [KIDX_W-1:0] o_key_idx,
    input  logic [127:0]      i_round_key,
    output logic [127:0]      o_rnd_data,
    output logic              o_last_rnd,
    input  logic [127:0]      i_rnd_data,
    output logic              o_valid,
    input  logic              i_ready,
`ifdef AES_KEY_VALID_EN
    input  logic              i_key_valid,
`endif
    output logic [127:0]      o_data,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // The initial AddRoundKey uses key NR. The rounds then count down from NR-1.
    localparam logic [KIDX_W-1:0] KIDX_INIT  = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] KIDX_FIRST = KIDX_W'(NR - 1);
    localparam logic [KIDX_W-1:0] KIDX_ZERO  = {KIDX_W{1'b0}};
    localparam logic [KIDX_W-1:0] KIDX_ONE   = {{(KIDX_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_nxt_s;
    logic [KIDX_W-1:0]   cnt_r;
    logic [KIDX_W-1:0]   cnt_nxt_s;
    logic [127:0]        data_r;
    logic [127:0]        data_nxt_s;
    logic                key_ok_s;
    logic                cnt_zero_s;

`ifdef AES_KEY_VALID_EN
    assign key_ok_s = i_key_valid;
`else
    assign key_ok_s = 1'b1;
`endif

    assign cnt_zero_s = (cnt_r == KIDX_ZERO);

    // State, round-counter and block registers, with asynchronous reset to the idle values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= KIDX_ZERO;
            data_r  <= 128'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            data_r  <= data_nxt_s;
        end
    end

    // Next-state logic. A flush wins over everything and keeps the block register contents.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        data_nxt_s  = data_r;
        if (i_flush) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = KIDX_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_valid && key_ok_s) begin
                        data_nxt_s  = i_data ^ i_round_key;
                        cnt_nxt_s   = KIDX_FIRST;
                        state_nxt_s = ST_ROUND;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ROUND: begin
                    if (key_ok_s) begin
                        data_nxt_s = i_rnd_data;
                        if (cnt_zero_s) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            cnt_nxt_s = cnt_r - KIDX_ONE;
                        end
                    end else begin
                        state_nxt_s = ST_ROUND;
                    end
                end
                ST_DONE: begin
                    // The handshake returns to IDLE only. The next block is taken one cycle later.
                    if (i_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = KIDX_ZERO;
                end
            endcase
        end
    end

    // Output decode from the state register. o_in_ready also depends on flush and key availability.
    always_comb begin
        o_in_ready = 1'b0;
        o_key_idx  = KIDX_INIT;
        o_last_rnd = 1'b0;
        o_valid    = 1'b0;
        o_busy     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                o_in_ready = ~i_flush & key_ok_s;
            end
            ST_ROUND: begin
                o_key_idx  = cnt_r;
                o_last_rnd = cnt_zero_s;
                o_busy     = 1'b1;
            end
            ST_DONE: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    // The datapath operand and the plaintext both come from the block register.
    assign o_rnd_data = data_r;
    assign o_data     = data_r;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_round_ctrl
//
// The bench provides the external inverse-round datapath and the round-key
// store for the key 000102..0f. It also keeps a reference model that
// decrypts a whole block, plus a position counter that tracks each block's
// progress. A compare process checks every DUT output against that model on
// each falling edge. Directed tests cover reset, the FIPS-197 C.1 vector,
// the key-index sequence, backpressure and flush. When AES_KEY_VALID_EN is
// defined, a key-valid stall test is added.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_inv_round_ctrl;
    localparam int NR     = 10;
    localparam int KIDX_W = 4;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT2 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT3 = 128'hdeadbeefcafebabe0011223344556677;

    logic clk = 1'b0;
    logic rst, i_flush, i_valid, i_ready, key_valid;
    logic [127:0] i_data, i_round_key, i_rnd_data, o_rnd_data, o_data;
    logic o_in_ready, o_last_rnd, o_valid, o_busy;
    logic [KIDX_W-1:0] o_key_idx;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox  [0:255];
    logic [7:0]   isbox [0:255];
    logic [31:0]  w     [0:43];
    logic [127:0] rk    [0:15];

    always #5 clk = ~clk;

    aes_inv_round_ctrl #(.NR(NR), .KIDX_W(KIDX_W)) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid),
        .o_in_ready(o_in_ready), .i_data(i_data), .o_key_idx(o_key_idx),
        .i_round_key(i_round_key), .o_rnd_data(o_rnd_data), .o_last_rnd(o_last_rnd),
        .i_rnd_data(i_rnd_data), .o_valid(o_valid), .i_ready(i_ready),
`ifdef AES_KEY_VALID_EN
        .i_key_valid(key_valid),
`endif
        .o_data(o_data), .o_busy(o_busy)
    );

    // ---------------- AES helpers ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'd0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = gb(s, 4*((c-r+4)%4)+r);
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'd0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = isbox[gb(s, i)];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = gmul(a0,8'h0e)^gmul(a1,8'h0b)^gmul(a2,8'h0d)^gmul(a3,8'h09);
            o[127-8*(4*c+1) -: 8] = gmul(a0,8'h09)^gmul(a1,8'h0e)^gmul(a2,8'h0b)^gmul(a3,8'h0d);
            o[127-8*(4*c+2) -: 8] = gmul(a0,8'h0d)^gmul(a1,8'h09)^gmul(a2,8'h0e)^gmul(a3,8'h0b);
            o[127-8*(4*c+3) -: 8] = gmul(a0,8'h0b)^gmul(a1,8'h0d)^gmul(a2,8'h09)^gmul(a3,8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        t = inv_sub_bytes(inv_shift_rows(s)) ^ k;
        return last ? t : inv_mix_columns(t);
    endfunction

    // Whole-block reference decryption with the standard inverse cipher.
    function automatic logic [127:0] aes_dec(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rk[NR];
        for (int r = NR - 1; r >= 0; r--) s = inv_round(s, rk[r], r == 0);
        return s;
    endfunction

    // External datapath and key store seen by the DUT.
    assign i_round_key = rk[o_key_idx];
    assign i_rnd_data  = inv_round(o_rnd_data, i_round_key, o_last_rnd);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // pos: -1 = no block, 1..NR = round step (uses key NR-pos), NR+1 = result waiting
    int pos = -1;
    logic [127:0] mdata = 128'd0;

    // Tracks each block's progress from the handshake and flush rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= -1;
        end else if (i_flush) begin
            pos <= -1;
        end else if (pos < 0) begin
            if (i_valid && key_valid) begin
                pos   <= 1;
                mdata <= aes_dec(i_data);
            end
        end else if (pos <= NR) begin
            if (key_valid) pos <= pos + 1;
        end else begin
            if (i_ready) pos <= -1;
        end
    end

    // Checks every DUT output against the model in the middle of each cycle.
    always @(negedge clk) begin
        check("in_ready",  {127'd0, o_in_ready}, {127'd0, (pos < 0) && !i_flush && key_valid});
        check("valid",     {127'd0, o_valid},    {127'd0, pos == NR + 1});
        check("busy",      {127'd0, o_busy},     {127'd0, pos >= 1});
        check("last_rnd",  {127'd0, o_last_rnd}, {127'd0, pos == NR});
        check("key_idx",   {124'd0, o_key_idx},
              (pos >= 1 && pos <= NR) ? 128'(NR - pos) : 128'(NR));
        if (pos == NR + 1) check("data", o_data, mdata);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    logic [7:0]   inv, s8, rc;
    logic [31:0]  t;
    logic [127:0] key_v, held, got;
    logic [KIDX_W-1:0] seq_idx [0:NR];
    logic              seq_last[0:NR];
    int lat, n, cyc;

    initial begin
        rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_data = 128'd0; key_valid = 1'b1;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s8 = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                     ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]   = s8;
            isbox[s8] = 8'(x);
        end
        key_v = KEY;
        for (int i = 0; i < 4; i++) w[i] = key_v[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'd0;

        // Hand-computed values that pin the model itself.
        check("model_rk10", rk[NR], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("model_fips", aes_dec(CT1), PT1);

        // Reset values while rst is held.
        #3;
        check("rst_valid",   {127'd0, o_valid},   128'd0);
        check("rst_busy",    {127'd0, o_busy},    128'd0);
        check("rst_key_idx", {124'd0, o_key_idx}, 128'd10);
        check("rst_last",    {127'd0, o_last_rnd},128'd0);
        check("rst_state",   o_rnd_data,          128'd0);
        @(posedge clk); #2 rst = 1'b0;

        // FIPS-197 C.1, latency and key-index sequence.
        step();
        i_valid = 1'b1; i_data = CT1; i_ready = 1'b1;
        #1;
        seq_idx[0] = o_key_idx; seq_last[0] = o_last_rnd;
        @(posedge clk); #2; i_valid = 1'b0; #1;
        lat = 0; got = 128'd0;
        for (int i = 1; i <= 20; i++) begin
            if (i <= NR) begin seq_idx[i] = o_key_idx; seq_last[i] = o_last_rnd; end
            if (o_valid && lat == 0) begin lat = i; got = o_data; end
            @(posedge clk); #3;
        end
        for (int i = 0; i <= NR; i++) begin
            check("seq_key_idx", {124'd0, seq_idx[i]}, 128'(NR - i));
            check("seq_last",    {127'd0, seq_last[i]}, {127'd0, i == NR});
        end
        check("fips_latency", 128'(lat), 128'd11);
        check("fips_plain",   got, PT1);

        // Backpressure in DONE, then accept the next block one cycle after the release.
        step();
        i_ready = 1'b0; i_valid = 1'b1; i_data = CT2;
        step();
        i_data = CT3;
        n = 0;
        while (!o_valid && n < 30) begin step(); n++; end
        check("bp_reach_done", {127'd0, o_valid}, 128'd1);
        held = o_data;
        for (int i = 0; i < 5; i++) begin
            check("bp_data_stable", o_data, held);
            check("bp_in_ready",    {127'd0, o_in_ready}, 128'd0);
            step();
        end
        i_ready = 1'b1;
        step();
        check("bp_idle_busy",  {127'd0, o_busy},     128'd0);
        check("bp_idle_ready", {127'd0, o_in_ready}, 128'd1);
        step();
        check("bp_next_accept", {127'd0, o_busy}, 128'd1);
        i_valid = 1'b0;
        n = 0;
        while (o_busy && n < 40) begin step(); n++; end
        check("bp_block3_done", {127'd0, o_busy}, 128'd0);

        // Flush mid-block at cnt=4, then flush together with valid in IDLE.
        i_valid = 1'b1; i_data = CT1;
        step();
        i_valid = 1'b0;
        n = 0;
        while (o_key_idx != 4'd4 && n < 30) begin step(); n++; end
        check("fl_reach_idx4", {124'd0, o_key_idx}, 128'd4);
        i_flush = 1'b1;
        step();
        check("fl_idle_busy", {127'd0, o_busy},     128'd0);
        check("fl_no_valid",  {127'd0, o_valid},    128'd0);
        check("fl_key_idx",   {124'd0, o_key_idx},  128'd10);
        i_valid = 1'b1;
        #1;
        check("fl_ready_masked", {127'd0, o_in_ready}, 128'd0);
        step();
        check("fl_not_accepted", {127'd0, o_busy}, 128'd0);
        i_flush = 1'b0; i_valid = 1'b0;
        step();

        // Asynchronous reset in the middle of a block at cnt=5.
        i_valid = 1'b1; i_data = CT2;
        step();
        i_valid = 1'b0;
        n = 0;
        while (o_key_idx != 4'd5 && n < 30) begin step(); n++; end
        check("ar_reach_idx5", {124'd0, o_key_idx}, 128'd5);
        #1 rst = 1'b1;
        #1;
        check("ar_valid",   {127'd0, o_valid},   128'd0);
        check("ar_busy",    {127'd0, o_busy},    128'd0);
        check("ar_key_idx", {124'd0, o_key_idx}, 128'd10);
        check("ar_state",   o_rnd_data,          128'd0);
        #3 rst = 1'b0;
        step();

`ifdef AES_KEY_VALID_EN
        // Key-valid stall of 3 cycles at cnt=7.
        i_valid = 1'b1; i_data = CT1;
        step();
        i_valid = 1'b0; cyc = 1;
        while (o_key_idx != 4'd7 && cyc < 30) begin step(); cyc++; end
        key_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("kv_hold_idx", {124'd0, o_key_idx}, 128'd7);
            step(); cyc++;
        end
        key_valid = 1'b1;
        while (!o_valid && cyc < 40) begin step(); cyc++; end
        check("kv_latency", 128'(cyc), 128'd14);
        check("kv_plain",   o_data,    PT1);
        step();
`endif

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
